// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO UART transmit path.
//   uart_tx_state_t : transmit FSM state encoding
//   UART_TX_ADDR    : byte address of the transmit data register on the core's write bus
//   UART_DATA_BITS  : data bits per frame (8N1)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    localparam logic [31:0] UART_TX_ADDR   = 32'h0000_1000;
    localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
// Ports:
//   clk_i    : clock, all logic on posedge
//   rst_i    : synchronous active-high reset, empties the FIFO
//   push_i   : write request; ignored while full
//   wdata_i  : write data
//   pop_i    : read request; ignored while empty
//   rdata_o  : head-of-queue data, valid whenever empty_o is low
//   full_o   : count == DEPTH
//   empty_o  : count == 0
//   count_o  : number of stored entries
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Full/empty come from the registered count, so a pop in the same cycle
    // never frees room for a push that cycle.
    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so pointer arithmetic wraps naturally.
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// MMIO UART transmitter: buffers bytes written by the core and emits them as 8N1 on txd_o.
// A full FIFO drops the write and sets a sticky overflow flag instead of stalling the bus.
// Ports:
//   clk_i        : clock, all logic on posedge
//   rst_i        : synchronous active-high reset; aborts any frame, discards queued bytes
//   tx_en_i      : write strobe, one byte per asserted cycle
//   tx_data_i    : write-bus data, only [7:0] is transmitted
//   tx_ready_o   : FIFO not full
//   fifo_count_o : bytes queued, excluding the byte on the wire
//   busy_o       : frame in progress or bytes queued
//   overflow_o   : sticky, a write arrived while full
//   txd_o        : registered serial output, idles high
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 868,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          tx_en_i,
    input  logic [31:0]                   tx_data_i,
    output logic                          tx_ready_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o,
    output logic                          overflow_o,
    output logic                          txd_o
);

    localparam int unsigned BaudW = $clog2(CLK_DIV);
    localparam logic [BaudW-1:0] BaudLoad = BaudW'(CLK_DIV - 1);
    localparam logic [2:0] BitLast = 3'(UART_DATA_BITS - 1);

    uart_tx_state_t                state_q, state_d;
    logic [BaudW-1:0]              baud_q, baud_d;
    logic [2:0]                    bit_idx_q, bit_idx_d;
    logic [UART_DATA_BITS-1:0]     shift_q, shift_d;
    logic                          txd_q, txd_d;
    logic                          overflow_q, overflow_d;

    logic                          fifo_pop;
    logic                          fifo_full;
    logic                          fifo_empty;
    logic [UART_DATA_BITS-1:0]     fifo_rdata;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          baud_done;

    // Upper write-bus bits are deliberately dropped at the FIFO input.
    logic unused_tx_data_hi;
    assign unused_tx_data_hi = ^tx_data_i[31:UART_DATA_BITS];

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (tx_en_i),
        .wdata_i (tx_data_i[UART_DATA_BITS-1:0]),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign baud_done = (baud_q == '0);

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = START;
                    baud_d   = BaudLoad;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    baud_d    = BaudLoad;
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = BaudLoad;
                    if (bit_idx_q == BitLast) begin
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    // Chain straight into the next start bit to keep frames contiguous.
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_rdata;
                        state_d  = START;
                        baud_d   = BaudLoad;
                    end else begin
                        state_d = IDLE;
                        baud_d  = '0;
                    end
                end else begin
                    baud_d = baud_q - BaudW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                baud_d  = '0;
            end
        endcase

        // txd is decoded from next state so the register lines up with state_q.
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase

        overflow_d = overflow_q | (tx_en_i & fifo_full);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
            overflow_q <= overflow_d;
        end
    end

    assign txd_o        = txd_q;
    assign tx_ready_o   = !fifo_full;
    assign fifo_count_o = fifo_count;
    assign busy_o       = (state_q != IDLE) || !fifo_empty;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer with CLK_DIV=4, FIFO_DEPTH=4.
// Accepted bytes go into a scoreboard queue; a line monitor decodes every frame on txd
// and pops the queue to compare.
module tb_uart_tx_serializer;

    localparam int unsigned CLK_DIV    = 4;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FRAME      = 10 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_en;
    logic [31:0] tx_data;
    logic        tx_ready;
    logic [2:0]  fifo_count;
    logic        busy;
    logic        overflow;
    logic        txd;

    uart_tx_serializer #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tx_en_i      (tx_en),
        .tx_data_i    (tx_data),
        .tx_ready_o   (tx_ready),
        .fifo_count_o (fifo_count),
        .busy_o       (busy),
        .overflow_o   (overflow),
        .txd_o        (txd)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  sb[$];
    int unsigned starts[$];
    int unsigned frames_done = 0;
    int unsigned max_count = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one write; it is sampled at the next posedge. acc = index of that edge.
    task automatic push(input logic [31:0] d, input bit accept, output int unsigned acc);
        tx_en   = 1'b1;
        tx_data = d;
        if (accept) sb.push_back(d[7:0]);
        @(posedge clk);
        #1;
        tx_en = 1'b0;
        acc   = cyc;
    endtask

    task automatic wait_until(input int unsigned target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(output int unsigned t);
        int n = 0;
        @(negedge clk);
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        t = cyc;
        check("idle_timeout", busy, 1'b0);
    endtask

    // Line monitor: frame starts on first low sample; each bit must hold for CLK_DIV samples.
    initial begin
        int         off;
        logic [9:0] bits;
        bit         bad;
        bit         in_frame;
        logic [7:0] exp_b;
        in_frame = 1'b0;
        off      = 0;
        bits     = '0;
        bad      = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_frame = 1'b0;
                continue;
            end
            if (fifo_count > max_count) max_count = fifo_count;
            if (!in_frame && txd === 1'b0) begin
                in_frame = 1'b1;
                off      = 0;
                bad      = 1'b0;
                starts.push_back(cyc);
            end
            if (in_frame) begin
                if ($isunknown(txd)) bad = 1'b1;
                if (off % CLK_DIV == 0) bits[off / CLK_DIV] = txd;
                else if (txd !== bits[off / CLK_DIV]) bad = 1'b1;
                off++;
                if (off == FRAME) begin
                    in_frame = 1'b0;
                    frames_done++;
                    check("frame_expected", (sb.size() != 0), 1'b1);
                    if (sb.size() != 0) begin
                        exp_b = sb.pop_front();
                        check("frame_byte", bits[8:1], exp_b);
                    end
                    check("stop_bit", bits[9], 1'b1);
                    check("bit_stable", bad, 1'b0);
                end
            end
        end
    end

    initial begin
        int unsigned a;
        int unsigned d;
        int unsigned t;

        rst     = 1'b1;
        tx_en   = 1'b0;
        tx_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_txd", txd, 1'b1);
        check("rst_tx_ready", tx_ready, 1'b1);
        check("rst_count", fifo_count, 3'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_overflow", overflow, 1'b0);

        // Single byte 0xA5
        starts.delete();
        push(32'h0000_00A5, 1'b1, a);
        check("a5_count", fifo_count, 3'd1);
        check("a5_busy", busy, 1'b1);
        check("a5_txd_still_idle", txd, 1'b1);
        wait_idle(t);
        check("a5_nstarts", starts.size(), 1);
        if (starts.size() != 0) check("a5_start_latency", starts[0], a + 1);
        check("a5_busy_drop", t, a + 1 + FRAME);

        // Burst of three back-to-back writes
        starts.delete();
        max_count = 0;
        push(32'h0000_0001, 1'b1, a);
        push(32'h0000_0002, 1'b1, d);
        push(32'h0000_0003, 1'b1, d);
        wait_idle(t);
        check("burst_nstarts", starts.size(), 3);
        if (starts.size() == 3) begin
            check("burst_start0", starts[0], a + 1);
            check("burst_gap01", starts[1] - starts[0], FRAME);
            check("burst_gap12", starts[2] - starts[1], FRAME);
        end
        check("burst_peak_count", max_count, 2);

        // Six writes: fifth fills the FIFO, sixth is dropped
        push(32'h0000_0010, 1'b1, a);
        push(32'h0000_0011, 1'b1, d);
        push(32'h0000_0012, 1'b1, d);
        push(32'h0000_0013, 1'b1, d);
        push(32'h0000_0014, 1'b1, d);
        check("full_tx_ready", tx_ready, 1'b0);
        check("full_count", fifo_count, 3'd4);
        check("full_no_ovf_yet", overflow, 1'b0);
        push(32'h0000_0015, 1'b0, d);
        check("drop_overflow", overflow, 1'b1);
        check("drop_count", fifo_count, 3'd4);
        wait_idle(t);
        check("overflow_sticky", overflow, 1'b1);
        check("drained_tx_ready", tx_ready, 1'b1);

        // Reset clears overflow; then push on the exact cycle STOP pops a full FIFO
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst2_overflow", overflow, 1'b0);
        push(32'h0000_0020, 1'b1, a);
        push(32'h0000_0021, 1'b1, d);
        push(32'h0000_0022, 1'b1, d);
        push(32'h0000_0023, 1'b1, d);
        push(32'h0000_0024, 1'b1, d);
        wait_until(a + FRAME);
        check("stoppop_pre_count", fifo_count, 3'd4);
        check("stoppop_pre_ready", tx_ready, 1'b0);
        push(32'h0000_0099, 1'b0, d);
        check("stoppop_count", fifo_count, 3'd3);
        check("stoppop_overflow", overflow, 1'b1);
        check("stoppop_next_start", txd, 1'b0);
        wait_idle(t);

        // Reset in the middle of DATA for 0xFF with two bytes queued
        push(32'h0000_00FF, 1'b1, a);
        push(32'h0000_0001, 1'b1, d);
        push(32'h0000_0002, 1'b1, d);
        check("abort_pre_count", fifo_count, 3'd2);
        wait_until(a + 14);
        check("abort_pre_busy", busy, 1'b1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_txd", txd, 1'b1);
        check("abort_count", fifo_count, 3'd0);
        check("abort_busy", busy, 1'b0);
        starts.delete();
        push(32'h0000_003C, 1'b1, a);
        wait_idle(t);
        check("post_abort_nstarts", starts.size(), 1);
        check("post_abort_busy_drop", t, a + 1 + FRAME);

        // Unknown upper data bits must not disturb the frame
        push(32'hXXXX_XX5A, 1'b1, a);
        check("xdata_count", fifo_count, 3'd1);
        wait_idle(t);

        check("frames_done", frames_done, 16);
        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
